// File: rtl/rr_bank_port_arbiter.sv
// ---------------------------------------------------------------------------
// rr_bank_port_arbiter
//
// Shares a banked, multi-ported scratch memory among NCONSUMERS requesters.
// Every (bank, port) pair is a scheduling kernel with its own rotating
// round-robin pivot. Each cycle every kernel picks at most one requester that
// targets its bank. Lower-numbered ports of a bank choose first, and later
// ports skip consumers already claimed. Decisions are registered, so grants
// and crossbar selects appear one cycle after the request is sampled.
//
// Ports:
//   clk             - clock
//   reset           - synchronous, active-high reset
//   en              - arbitration enable; low freezes pivots, clears grants
//   req_valid       - per-consumer request
//   req_bank        - target bank of consumer c in [c*BW +: BW]
//   grant           - registered per-consumer grant
//   grant_port      - port granted to consumer c in [c*PW +: PW], 0 if idle
//   kernel_valid    - kernel k (bank*NPORTS+port) drives its port
//   kernel_consumer - consumer served by kernel k in [k*CW +: CW], 0 if idle
// ---------------------------------------------------------------------------
module rr_bank_port_arbiter #(
  parameter int NCONSUMERS = 8,
  parameter int NBANKS     = 4,
  parameter int NPORTS     = 2,
  localparam int NKERNELS  = NBANKS * NPORTS,
  localparam int CW        = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1,
  localparam int BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int PW        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NCONSUMERS-1:0]    req_valid,
  input  logic [NCONSUMERS*BW-1:0] req_bank,
  output logic [NCONSUMERS-1:0]    grant,
  output logic [NCONSUMERS*PW-1:0] grant_port,
  output logic [NKERNELS-1:0]      kernel_valid,
  output logic [NKERNELS*CW-1:0]   kernel_consumer
);

  // One extra bit so pivot + offset can exceed NCONSUMERS before wrapping.
  localparam int SW = CW + 1;

  // Reset pivots stagger the ports of a bank by NBANKS so that ports of the
  // same bank start scanning from different consumers.
  function automatic logic [CW-1:0] reset_pivot(input int k);
    int v;
    v = ((k / NPORTS) + (k % NPORTS) * NBANKS) % NCONSUMERS;
    return v[CW-1:0];
  endfunction

  logic [CW-1:0]         rr_pivots_q       [NKERNELS];
  logic [CW-1:0]         rr_pivots_d       [NKERNELS];
  logic [NCONSUMERS-1:0] grant_q;
  logic [NCONSUMERS-1:0] grant_d;
  logic [PW-1:0]         grant_port_q      [NCONSUMERS];
  logic [PW-1:0]         grant_port_d      [NCONSUMERS];
  logic [NKERNELS-1:0]   kernel_valid_q;
  logic [NKERNELS-1:0]   kernel_valid_d;
  logic [CW-1:0]         kernel_consumer_q [NKERNELS];
  logic [CW-1:0]         kernel_consumer_d [NKERNELS];

  logic [BW-1:0]         bank_of [NCONSUMERS];
  logic [NCONSUMERS-1:0] claimed;
  logic                  found;
  logic [CW-1:0]         pick;
  logic [SW-1:0]         scan;
  logic [CW-1:0]         cand;

  // Unpack the flat bank bus so the scan can index it by consumer number.
  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      bank_of[c] = req_bank[c*BW +: BW];
    end
  end

  // Pivots advance by one per enabled cycle with an explicit wrap, so a
  // non-power-of-two consumer count still sweeps every consumer.
  always_comb begin
    for (int k = 0; k < NKERNELS; k++) begin
      rr_pivots_d[k] = rr_pivots_q[k];
      if (en) begin
        if (rr_pivots_q[k] == CW'(NCONSUMERS - 1)) begin
          rr_pivots_d[k] = '0;
        end else begin
          rr_pivots_d[k] = rr_pivots_q[k] + 1'b1;
        end
      end
    end
  end

  // Per-bank, per-port round-robin scan. Ports of a bank are visited in
  // ascending order and share the claimed mask, so no consumer is granted
  // twice. A consumer targets exactly one bank, so a single mask for all
  // banks is sufficient. Banks outside 0..NBANKS-1 never match any kernel.
  always_comb begin
    grant_d = '0;
    kernel_valid_d = '0;
    claimed = '0;
    found = 1'b0;
    pick = '0;
    scan = '0;
    cand = '0;
    for (int c = 0; c < NCONSUMERS; c++) begin
      grant_port_d[c] = '0;
    end
    for (int k = 0; k < NKERNELS; k++) begin
      kernel_consumer_d[k] = '0;
    end
    if (en) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int p = 0; p < NPORTS; p++) begin
          found = 1'b0;
          pick = '0;
          for (int i = 0; i < NCONSUMERS; i++) begin
            scan = {1'b0, rr_pivots_q[b*NPORTS + p]} + SW'(i);
            if (scan >= SW'(NCONSUMERS)) begin
              scan = scan - SW'(NCONSUMERS);
            end
            cand = scan[CW-1:0];
            if (!found && req_valid[cand] && !claimed[cand] &&
                (bank_of[cand] == BW'(b))) begin
              found = 1'b1;
              pick = cand;
            end
          end
          if (found) begin
            claimed[pick] = 1'b1;
            grant_d[pick] = 1'b1;
            grant_port_d[pick] = PW'(p);
            kernel_valid_d[b*NPORTS + p] = 1'b1;
            kernel_consumer_d[b*NPORTS + p] = pick;
          end
        end
      end
    end
  end

  // All state and outputs update together; reset wins over en and requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      kernel_valid_q <= '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
        grant_port_q[c] <= '0;
      end
      for (int k = 0; k < NKERNELS; k++) begin
        rr_pivots_q[k] <= reset_pivot(k);
        kernel_consumer_q[k] <= '0;
      end
    end else begin
      grant_q <= grant_d;
      kernel_valid_q <= kernel_valid_d;
      for (int c = 0; c < NCONSUMERS; c++) begin
        grant_port_q[c] <= grant_port_d[c];
      end
      for (int k = 0; k < NKERNELS; k++) begin
        rr_pivots_q[k] <= rr_pivots_d[k];
        kernel_consumer_q[k] <= kernel_consumer_d[k];
      end
    end
  end

  // Pack registered arrays onto the flat output buses.
  always_comb begin
    grant = grant_q;
    kernel_valid = kernel_valid_q;
    grant_port = '0;
    kernel_consumer = '0;
    for (int c = 0; c < NCONSUMERS; c++) begin
      grant_port[c*PW +: PW] = grant_port_q[c];
    end
    for (int k = 0; k < NKERNELS; k++) begin
      kernel_consumer[k*CW +: CW] = kernel_consumer_q[k];
    end
  end

endmodule

// File: tb/tb_rr_bank_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_bank_port_arbiter
//
// Drives directed scenarios followed by random traffic into the arbiter.
// For every issued cycle a reference model computes the expected registered
// outputs and pushes them to a queue; a monitor pops one entry after each
// clock edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_rr_bank_port_arbiter;

  localparam int NC = 8;
  localparam int NB = 4;
  localparam int NP = 2;
  localparam int NK = NB * NP;
  localparam int CW = 3;
  localparam int BW = 2;
  localparam int PW = 1;

  typedef struct {
    logic [NC-1:0]    grant;
    logic [NC*PW-1:0] gport;
    logic [NK-1:0]    kvalid;
    logic [NK*CW-1:0] kcons;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             en;
  logic [NC-1:0]    req_valid;
  logic [NC*BW-1:0] req_bank;
  logic [NC-1:0]    grant;
  logic [NC*PW-1:0] grant_port;
  logic [NK-1:0]    kernel_valid;
  logic [NK*CW-1:0] kernel_consumer;

  exp_t expq[$];
  int   mpiv[NK];
  int   compared;
  int   mismatched;
  int   cycle_no;

  rr_bank_port_arbiter #(
    .NCONSUMERS(NC),
    .NBANKS(NB),
    .NPORTS(NP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .req_valid(req_valid),
    .req_bank(req_bank),
    .grant(grant),
    .grant_port(grant_port),
    .kernel_valid(kernel_valid),
    .kernel_consumer(kernel_consumer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pivots after reset: bank index plus port times bank count.
  function automatic void modelReset();
    for (int k = 0; k < NK; k++) begin
      mpiv[k] = ((k / NP) + (k % NP) * NB) % NC;
    end
  endfunction

  // Each kernel takes the eligible, unclaimed consumer at the smallest
  // forward distance from its pivot; ports of a bank choose in order.
  function automatic exp_t modelStep(input logic rst, input logic enable,
                                     input logic [NC-1:0] v,
                                     input logic [NC*BW-1:0] bk);
    exp_t e;
    bit   taken[NC];
    int   best;
    int   bestd;
    int   d;
    e.grant = '0;
    e.gport = '0;
    e.kvalid = '0;
    e.kcons = '0;
    for (int c = 0; c < NC; c++) taken[c] = 1'b0;
    if (rst) begin
      modelReset();
      return e;
    end
    if (!enable) return e;
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < NP; p++) begin
        best = -1;
        bestd = NC;
        for (int c = 0; c < NC; c++) begin
          if (v[c] && !taken[c] && (int'(bk[c*BW +: BW]) == b)) begin
            d = (c - mpiv[b*NP + p] + NC) % NC;
            if (d < bestd) begin
              bestd = d;
              best = c;
            end
          end
        end
        if (best >= 0) begin
          taken[best] = 1'b1;
          e.grant[best] = 1'b1;
          e.gport[best*PW +: PW] = PW'(p);
          e.kvalid[b*NP + p] = 1'b1;
          e.kcons[(b*NP + p)*CW +: CW] = CW'(best);
        end
      end
    end
    for (int k = 0; k < NK; k++) begin
      mpiv[k] = (mpiv[k] + 1) % NC;
    end
    return e;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue the response
  // expected after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic enable,
                               input logic [NC-1:0] v,
                               input logic [NC*BW-1:0] bk);
    @(negedge clk);
    reset = rst;
    en = enable;
    req_valid = v;
    req_bank = bk;
    expq.push_back(modelStep(rst, enable, v, bk));
  endtask

  task automatic checkOutput();
    exp_t e;
    e = expq.pop_front();
    cycle_no++;
    compared++;
    if (grant !== e.grant) begin
      mismatched++;
      $display("[TB] FAIL grant cycle %0d: got %b expected %b", cycle_no, grant, e.grant);
    end
    compared++;
    if (grant_port !== e.gport) begin
      mismatched++;
      $display("[TB] FAIL grant_port cycle %0d: got %b expected %b", cycle_no, grant_port, e.gport);
    end
    compared++;
    if (kernel_valid !== e.kvalid) begin
      mismatched++;
      $display("[TB] FAIL kernel_valid cycle %0d: got %b expected %b", cycle_no, kernel_valid, e.kvalid);
    end
    compared++;
    if (kernel_consumer !== e.kcons) begin
      mismatched++;
      $display("[TB] FAIL kernel_consumer cycle %0d: got %h expected %h", cycle_no, kernel_consumer, e.kcons);
    end
  endtask

  // Monitor: the DUT presents a fresh registered result after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput();
    end
  end

  logic [NC*BW-1:0] spread;
  logic [NC-1:0]    rv;
  logic [NC*BW-1:0] rb;
  logic             ren;
  logic             rrst;

  initial begin
    compared = 0;
    mismatched = 0;
    cycle_no = 0;
    reset = 1'b1;
    en = 1'b0;
    req_valid = '0;
    req_bank = '0;
    modelReset();
    for (int c = 0; c < NC; c++) spread[c*BW +: BW] = BW'(c % NB);

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b1, 1'b0, '0, '0);

    $display("[TB] single-bank contention");
    repeat (4) applyStimulus(1'b0, 1'b1, 8'hFF, '0);

    $display("[TB] port exclusion");
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 8'h10, '0);

    $display("[TB] full spread");
    repeat (2) applyStimulus(1'b0, 1'b1, 8'hFF, spread);

    $display("[TB] wrap-around");
    applyStimulus(1'b1, 1'b0, '0, '0);
    repeat (7) applyStimulus(1'b0, 1'b1, '0, '0);
    applyStimulus(1'b0, 1'b1, 8'h04, '0);
    applyStimulus(1'b0, 1'b1, 8'hFF, '0);

    $display("[TB] hold and reset");
    repeat (3) applyStimulus(1'b0, 1'b0, 8'hFF, spread);
    repeat (2) applyStimulus(1'b0, 1'b1, 8'hFF, spread);
    applyStimulus(1'b1, 1'b1, 8'hFF, spread);
    applyStimulus(1'b0, 1'b1, 8'hFF, '0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      rv = NC'($urandom);
      rb = (NC*BW)'($urandom);
      ren = ($urandom_range(0, 9) != 0);
      rrst = ($urandom_range(0, 59) == 0);
      applyStimulus(rrst, ren, rv, rb);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);

    for (int w = 0; w < 20 && expq.size() > 0; w++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_bank_port_arbiter.md
Name: rr_bank_port_arbiter

Overview:
- Shares a banked, multi-ported scratch memory among NCONSUMERS requesters.
- Each (bank, port) pair is a scheduling kernel, NKERNELS = NBANKS*NPORTS in total.
- Every kernel holds a rotating round-robin pivot and picks one requester for its port each cycle.
- Grants are registered and drive the bank crossbar select lines one cycle after the request.

Parameters:
- NCONSUMERS, 8: number of requesters; must be >= NKERNELS.
- NBANKS, 4: number of memory banks.
- NPORTS, 2: ports per bank.
- NKERNELS, NBANKS*NPORTS: localparam, number of kernels.
- CW, max(1,$clog2(NCONSUMERS)): localparam, consumer index width.
- BW, max(1,$clog2(NBANKS)): localparam, bank index width.
- PW, max(1,$clog2(NPORTS)): localparam, port index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  arbitration enable; low freezes the pivots and suppresses new grants.
- req_valid  in  NCONSUMERS  per-consumer request.
- req_bank  in  NCONSUMERS*BW  target bank of consumer c, in slice [c*BW +: BW].
- grant  out  NCONSUMERS  registered per-consumer grant.
- grant_port  out  NCONSUMERS*PW  port granted to consumer c; valid only while grant[c]=1, zero otherwise.
- kernel_valid  out  NKERNELS  kernel k drives its port this cycle.
- kernel_consumer  out  NKERNELS*CW  consumer served by kernel k; zero when kernel_valid[k]=0.

Behaviour:
- Kernel index: k = bank*NPORTS + port.
- Pivots: one CW-bit register per kernel, rr_pivots[k].
  - On reset, rr_pivots[k] = ((k / NPORTS) + (k % NPORTS)*NBANKS) mod NCONSUMERS. With defaults this is [0,4,1,5,2,6,3,7].
  - Each clock edge with reset=0 and en=1: rr_pivots[k] <= (rr_pivots[k]+1) mod NCONSUMERS. Wrap is explicit, NCONSUMERS need not be a power of two.
  - en=0: pivots hold.
- Arbitration is combinational in cycle t, uses pivots as registered at t, and resolves each bank independently.
  - Port 0 of bank b scans consumers pivot, pivot+1, ... mod NCONSUMERS. It takes the first c with req_valid[c]=1 and req_bank[c]==b.
  - Port p>0 scans the same way from its own pivot, excluding consumers already claimed by ports 0..p-1 of the same bank.
  - A consumer is never granted twice in one cycle. A kernel with no eligible consumer is idle.
- Output timing:
  - All outputs are registered; a request sampled at edge t is answered by grant visible after edge t (latency 1).
  - Pivots advance on that same edge, so the next decision uses the rotated pivots.
  - Requesters hold req_valid until they observe grant. There is no queueing; an ungranted request is simply re-arbitrated.
- en=0: at the next edge grant, kernel_valid, grant_port and kernel_consumer are all cleared.
- Reset values: grant=0, grant_port=0, kernel_valid=0, kernel_consumer=0, pivots as above.
- Reset mid-operation overrides en and requests. Outputs clear on the reset edge, and the first post-reset decision uses the reset pivots.
- req_bank >= NBANKS (only possible for non-power-of-two NBANKS): the request is ignored, never granted.
- Fairness: pivots sweep every consumer within NCONSUMERS enabled cycles. A continuously requesting consumer is granted within NCONSUMERS cycles.

Test Plan:
1. Reset check: hold reset 2 cycles -> rr_pivots = [0,4,1,5,2,6,3,7]; grant=0, kernel_valid=0.
2. Single-bank contention:
   - Stimulus: release reset with en=1; all 8 consumers request bank 0.
   - First grant: grant=8'b0001_0001, grant_port[0]=0, grant_port[4]=1, kernel_consumer[0]=0, kernel_consumer[1]=4.
   - Next cycle: consumers 1 and 5.
   - Two cycles after that: consumers 3 and 7.
3. Port exclusion: pivots [0,4,...]; only consumer 4 requests bank 0 -> grant[4]=1 with grant_port=0; kernel_valid[1]=0.
4. Full spread: consumer c requests bank c%4 -> grant=8'hFF; every kernel valid; each bank serves consumers b and b+4 on distinct ports.
5. Wrap-around: run until rr_pivots[0]=7; only consumer 2 requests bank 0 -> port 0 grants consumer 2, and pivot[0] wraps to 0.
6. Hold and reset:
   - en=0 for 3 cycles: pivots unchanged, grant=0 after the first edge.
   - Re-enable: arbitration resumes from the held pivots.
   - Assert reset while grants are active: all outputs 0 next edge; pivots return to [0,4,1,5,2,6,3,7].
